// File: rtl/mips_cpu_multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_multdiv_pkg
// Brief   : Shared op/state encodings and constants for the MIPS mult/div unit
// Revision: 1.0 - initial release
// ============================================================================
package mips_multdiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam int          ITER_DEFAULT = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_multdiv_if.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_multdiv_if
// Brief   : Execute-stage request / HI-LO result bundle for the mult/div unit
// Revision: 1.0 - initial release
// ============================================================================
interface mips_cpu_multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_multdiv_divstep.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_divstep
// Brief   : One combinational restoring-division step (shift in, trial subtract)
// Revision: 1.0 - initial release
// ============================================================================
module mips_cpu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {rem_i, bit_i};
    assign w_diff  = w_shift - {1'b0, divisor_i};
    // Sign bit of the widened difference tells whether the divisor fit.
    assign q_o     = ~w_diff[WIDTH];
    assign rem_o   = q_o ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_multdiv
// Brief   : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Revision: 1.0 - initial release
// ============================================================================
module mips_cpu_multdiv
    import mips_multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_cpu_multdiv_if.slave        bus
);
    localparam int CW = $clog2(ITER + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               isdiv_q, isdiv_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_remfix;

    assign w_signed  = ~bus.op_i[0];
    assign w_a_mag   = (w_signed && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign w_b_mag   = (w_signed && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

    // Right-shifting multiplier: multiplier sits in acc low half, product grows from the top.
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    mips_cpu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .bit_i     (acc_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (w_rem),
        .q_o       (w_qbit)
    );

    assign w_prod   = neg_res_q ? -acc_q : acc_q;
    assign w_quot   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_remfix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        araw_d    = araw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        isdiv_d   = isdiv_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    case (bus.op_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d     = {{WIDTH{1'b0}}, w_a_mag};
                            opnd_d    = w_b_mag;
                            araw_d    = bus.a_i;
                            neg_res_d = w_signed & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                            neg_rem_d = w_signed & bus.a_i[WIDTH-1];
                            isdiv_d   = bus.op_i[1];
                            div0_d    = (bus.b_i == '0);
                            cnt_d     = '0;
                            state_d   = bus.op_i[1] ? S_DIV : S_MUL;
                        end
                        OP_MTHI: hi_d = bus.a_i;
                        OP_MTLO: lo_d = bus.a_i;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {w_rem, acc_q[WIDTH-2:0], w_qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!isdiv_q) begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = araw_q;
                    lo_d = DIV0_QUOT;
                end else begin
                    hi_d = w_remfix;
                    lo_d = w_quot;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            araw_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            isdiv_q   <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            araw_q    <= araw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            isdiv_q   <= isdiv_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_cpu_multdiv
// Brief   : Directed-vector bench for mips_cpu_multdiv
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_cpu_multdiv;
    import mips_multdiv_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mips_cpu_multdiv_if #(.WIDTH(32)) bus_if ();

    mips_cpu_multdiv #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = op;
        bus_if.a_i     = a;
        bus_if.b_i     = b;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        bus_if.a_i     = 32'h0BAD_0BAD;
        bus_if.b_i     = 32'h0BAD_0BAD;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(op, a, b);
        cyc = 0;
        while (bus_if.busy_o && cyc < 60) begin
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, " busy cycles"}, 64'(cyc), 64'd33);
        check_eq({tag, " done"}, 64'(bus_if.done_o), 64'd1);
        check_eq({tag, " hi"}, 64'(bus_if.hi_o), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(bus_if.lo_o), 64'(exp_lo));
        @(negedge clk);
        check_eq({tag, " done drop"}, 64'(bus_if.done_o), 64'd0);
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus_if.start_i = 1'b0;
        bus_if.op_i    = 3'b000;
        bus_if.a_i     = '0;
        bus_if.b_i     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(bus_if.busy_o), 64'd0);
        check_eq("reset done", 64'(bus_if.done_o), 64'd0);
        check_eq("reset hi", 64'(bus_if.hi_o), 64'd0);
        check_eq("reset lo", 64'(bus_if.lo_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -2x3", OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("mult -1x-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("div -7/2",  OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div min/-1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div -7/0",  OP_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = OP_MTHI;
        bus_if.a_i     = 32'h1234_5678;
        @(negedge clk);
        check_eq("mthi hi", 64'(bus_if.hi_o), 64'h1234_5678);
        check_eq("mthi lo kept", 64'(bus_if.lo_o), 64'hFFFF_FFFF);
        check_eq("mthi busy", 64'(bus_if.busy_o), 64'd0);
        bus_if.op_i = OP_MTLO;
        bus_if.a_i  = 32'hCAFE_BABE;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        check_eq("mtlo lo", 64'(bus_if.lo_o), 64'hCAFE_BABE);
        check_eq("mtlo hi kept", 64'(bus_if.hi_o), 64'h1234_5678);
        check_eq("mtlo busy", 64'(bus_if.busy_o), 64'd0);
        check_eq("mtlo done", 64'(bus_if.done_o), 64'd0);

        // Reserved opcode is a no-op
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = 3'b110;
        bus_if.a_i     = 32'h5555_5555;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        check_eq("rsvd busy", 64'(bus_if.busy_o), 64'd0);
        check_eq("rsvd hi", 64'(bus_if.hi_o), 64'h1234_5678);

        // MULTU 3x7 with start held during busy; an MTHI mid-flight must be dropped
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = OP_MULTU;
        bus_if.a_i     = 32'd3;
        bus_if.b_i     = 32'd7;
        @(negedge clk);
        cyc = 0;
        while (bus_if.busy_o && cyc < 60) begin
            cyc++;
            if (cyc == 10) begin
                bus_if.op_i = OP_MTHI;
                bus_if.a_i  = 32'hDEAD_BEEF;
            end
            if (cyc == 15) check_eq("busy mthi ignored", 64'(bus_if.hi_o), 64'h1234_5678);
            if (cyc == 20) bus_if.start_i = 1'b0;
            @(negedge clk);
        end
        check_eq("held busy cycles", 64'(cyc), 64'd33);
        check_eq("held done", 64'(bus_if.done_o), 64'd1);
        check_eq("held hi", 64'(bus_if.hi_o), 64'd0);
        check_eq("held lo", 64'(bus_if.lo_o), 64'd21);
        @(negedge clk);
        check_eq("held no relaunch", 64'(bus_if.busy_o), 64'd0);

        // Async reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check_eq("pre-rst busy", 64'(bus_if.busy_o), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async rst busy", 64'(bus_if.busy_o), 64'd0);
        check_eq("async rst done", 64'(bus_if.done_o), 64'd0);
        check_eq("async rst hi", 64'(bus_if.hi_o), 64'd0);
        check_eq("async rst lo", 64'(bus_if.lo_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post-rst idle", 64'(bus_if.busy_o), 64'd0);
        run_op("multu 3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mips_cpu_multdiv.md
Name: mips_cpu_multdiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the Harvard MIPS core. It sits directly downstream of the register file and consumes rs/rt read data (rd1/rd2) in the execute stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO to the MFHI/MFLO write-back mux and raises busy so the control path stalls the PC enable.

Parameters:
WIDTH, 32, operand width; only 32 is supported and verified.
ITER, WIDTH, number of shift-add / restoring-subtract iterations.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low; clock clk.
start  in  1  launches op; sampled only when busy=0.
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
a  in  WIDTH  rs operand (dividend / multiplicand / MTxx data).
b  in  WIDTH  rt operand (divisor / multiplier).
busy  out  1  high while a mult/div is in flight.
done  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal operands cleared. Applies immediately, including mid-operation; the in-flight op is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 at edge E0:
  - MULT/MULTU/DIV/DIVU: latch a and b, or their magnitudes for signed ops. Record the result sign (a[31]^b[31]) and the remainder sign (a[31]). Clear the counter and go to MUL or DIV; busy=1 from E0. a and b are don't-care after E0.
  - MTHI: hi<=a at E0. MTLO: lo<=a at E0. Stay in IDLE; busy and done stay 0.
  - Reserved op: ignored, no state change.
- MUL: one shift-add step per edge into a 2*WIDTH accumulator, ITER edges (E1..E32), then FIX.
- DIV: one restoring shift/subtract step per edge, ITER edges (E1..E32), then FIX.
- FIX (edge E33):
  - Negate the 64-bit product if the signed op had differing signs. For signed div, negate the quotient if the signs differ and negate the remainder if a was negative.
  - Write hi/lo (mult: hi=product[63:32], lo=product[31:0]; div: lo=quotient, hi=remainder).
  - busy<=0, done<=1, go to IDLE.
- Timing: busy is high for exactly 33 cycles after E0. done is high for exactly one cycle, coincident with the first busy=0 cycle; hi/lo are valid in that cycle.
- start while busy=1: ignored, including MTHI/MTLO; control must stall.
- start at the edge where FIX completes: not accepted (busy is still 1 at that edge). It is accepted at the next edge.
- Divide by zero, signed or unsigned: no trap. lo=0xFFFFFFFF and hi=a (raw dividend); no sign fix applied.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and must not be special-cased wrongly.
- hi/lo change only on FIX, MTHI, MTLO or reset.

Decomposition:
- Package mips_multdiv_pkg holds:
  - op_t enum (the 3-bit encodings above) and state_t enum (IDLE, MUL, DIV, FIX).
  - Constants ITER_DEFAULT=32 and DIV0_QUOT=32'hFFFFFFFF.
- One natural sub-module: mips_cpu_divstep, a combinational single restoring step. Inputs are the partial remainder, the dividend bit and the divisor; outputs are the new remainder and the quotient bit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 busy cycles: done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFE (-2) b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULT -1 x -1 -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/7 -> lo=14, hi=2.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, done after 33 cycles.
- MTHI 0x12345678 then MTLO 0xCAFEBABE on back-to-back edges -> hi and lo update at their respective edges; busy and done stay 0. A MULTU with start held high during busy launches only once; an MTHI issued while busy leaves hi unchanged.
- During DIV, pull reset low asynchronously mid-cycle at iteration 10 -> busy, done, hi, lo read 0 before the next clock edge. After reset is released, MULTU 3x5 yields hi=0, lo=15.
